// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with circular return-address stack
//
// Purpose: holds the word-addressed instruction address and applies one of
// hold / increment / jump / relative branch / call / return / call-relative
// each cycle, selected by the decoder. Calls and returns use an internal
// circular return-address stack (RAS) whose oldest entry is overwritten
// when a call arrives while it is full.
//
// Build option: define PC_RAS_EN to build the RAS. Without it, CALL acts as
// JMP, CALLR acts as BR, RET holds pc and flags err, and the RAS status
// outputs are constant (count 0, empty 1, full 0, ovf 0).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   stall      in   freeze pc and RAS state; op ignored
//   op         in   3-bit operation select
//   in         in   WIDTH-bit jump target or two's-complement offset
//   pc         out  current instruction address
//   ras_count  out  number of valid RAS entries
//   ras_empty  out  ras_count == 0
//   ras_full   out  ras_count == RAS_DEPTH
//   ras_ovf    out  one-cycle pulse: a call overwrote the oldest entry
//   err        out  one-cycle pulse: return on empty RAS or reserved op

module pc_sequencer #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0800,
  parameter int          RAS_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             in,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_ovf,
  output logic                         err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VALUE);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_INC   = 3'b001,
    OP_JMP   = 3'b010,
    OP_BR    = 3'b011,
    OP_CALL  = 3'b100,
    OP_RET   = 3'b101,
    OP_CALLR = 3'b110
  } op_e;

  op_e              op_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] pc_n;
  logic             err_n;

  assign op_q   = op_e'(op);
  assign pc_inc = pc + WIDTH'(1);
  assign pc_rel = pc + in;   // offset is two's complement, modulo wrap is intended

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr, ptr_n;       // ptr addresses the current top entry
  logic [CW-1:0]    cnt, cnt_n;
  logic             push, pop, ovf_n, ovf_q;
`endif

  always_comb begin
    pc_n  = pc;
    err_n = 1'b0;
`ifdef PC_RAS_EN
    push  = 1'b0;
    pop   = 1'b0;
`endif
    if (!stall) begin
      case (op_q)
        OP_HOLD: pc_n = pc;
        OP_INC:  pc_n = pc_inc;
        OP_JMP:  pc_n = in;
        OP_BR:   pc_n = pc_rel;
        OP_CALL: begin
          pc_n = in;
`ifdef PC_RAS_EN
          push = 1'b1;
`endif
        end
        OP_RET: begin
`ifdef PC_RAS_EN
          if (cnt != '0) begin
            pc_n = ras_mem[ptr];
            pop  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
`else
          err_n = 1'b1;
`endif
        end
        OP_CALLR: begin
          pc_n = pc_rel;
`ifdef PC_RAS_EN
          push = 1'b1;
`endif
        end
        default: err_n = 1'b1;   // reserved encoding 111
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RST_PC;
      err <= 1'b0;
    end else begin
      pc  <= pc_n;
      err <= err_n;
    end
  end

`ifdef PC_RAS_EN
  // A push while full still advances the pointer, so the new entry lands on
  // the oldest slot; the count saturates instead of wrapping.
  always_comb begin
    ptr_n = ptr;
    cnt_n = cnt;
    ovf_n = 1'b0;
    if (push) begin
      ptr_n = ptr + PW'(1);
      if (cnt == CW'(RAS_DEPTH)) ovf_n = 1'b1;
      else                       cnt_n = cnt + CW'(1);
    end else if (pop) begin
      ptr_n = ptr - PW'(1);
      cnt_n = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      ovf_q <= ovf_n;
    end
  end

  // Contents need no reset; only the count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) ras_mem[ptr_n] <= pc_inc;
  end

  assign ras_count = cnt;
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CW'(RAS_DEPTH));
  assign ras_ovf   = ovf_q;
`else
  assign ras_count = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
`endif

endmodule
